// File: rtl/cache_frontend.sv
// cache_frontend: request/response front end for a set-associative cache.
//   Accepts one read or write request at a time, drives the cache strobes,
//   collects hit/data, and presents a single registered response.
// Ports:
//   clock, reset_n               clock (rising edge), async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write/req_addr/req_data  request kind, address, write data
//   cache_addr/cache_val         latched address / write data toward the cache
//   cache_read/cache_write       cache strobes (never both)
//   cache_hit/cache_out_val      registered cache lookup result
//   rsp_valid/rsp_ready          response handshake
//   rsp_hit/rsp_err/rsp_data     first-lookup residency, write timeout, read data
//   hit_count/miss_count         saturating 16-bit statistics
module cache_frontend #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K          = 2,
  parameter int TIMEOUT    = 2*K+4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [LINE_WIDTH-1:0] cache_val,
  output logic                  cache_read,
  output logic                  cache_write,
  input  logic                  cache_hit,
  input  logic [LINE_WIDTH-1:0] cache_out_val,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  output logic [LINE_WIDTH-1:0] rsp_data,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, WR_WAIT, RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q, cache_read_q, cache_write_q;
  logic                  rsp_valid_q, rsp_hit_q, rsp_err_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic [LINE_WIDTH-1:0] cache_val_q, rsp_data_q;
  logic [15:0]           hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic [CW-1:0]         wcnt_q;
  logic                  rec_en;

  // Residency is recorded exactly once per request: in RD_CAPT for reads,
  // on the first WR_WAIT cycle for writes (WR_ISSUE sees a stale hit).
  always_comb begin
    rec_en       = (state_q == RD_CAPT) || ((state_q == WR_WAIT) && (wcnt_q == '0));
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (rec_en) begin
      if (cache_hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      cache_read_q  <= 1'b0;
      cache_write_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
      cache_addr_q  <= '0;
      cache_val_q   <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      wcnt_q        <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q  <= 1'b0;
            cache_addr_q <= req_addr;
            cache_val_q  <= req_data;
            if (req_write) begin
              cache_write_q <= 1'b1;
              wcnt_q        <= '0;
              state_q       <= WR_ISSUE;
            end else begin
              cache_read_q <= 1'b1;
              state_q      <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          cache_read_q <= 1'b0;
          state_q      <= RD_CAPT;
        end
        RD_CAPT: begin
          rsp_hit_q   <= cache_hit;
          rsp_data_q  <= cache_hit ? cache_out_val : '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        WR_ISSUE: state_q <= WR_WAIT;
        WR_WAIT: begin
          if (wcnt_q == '0) rsp_hit_q <= cache_hit;
          if (cache_hit) begin
            // Strobe drops on this edge; the cache may still see one more
            // cycle of the same write, which is harmless.
            cache_write_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
            cache_write_q <= 1'b0;
            rsp_err_q     <= 1'b1;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            wcnt_q <= wcnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign cache_read  = cache_read_q;
  assign cache_write = cache_write_q;
  assign cache_addr  = cache_addr_q;
  assign cache_val   = cache_val_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_data    = rsp_data_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_cache_frontend.sv
// Bench for cache_frontend: behavioural registered cache model, scoreboard of
// expected responses, one task per scenario.
module tb_cache_frontend;
  localparam int AW = 8;
  localparam int LW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_data = '0;
  logic          req_ready, cache_read, cache_write, cache_hit;
  logic [AW-1:0] cache_addr;
  logic [LW-1:0] cache_val, cache_out_val, rsp_data;
  logic          rsp_valid, rsp_hit, rsp_err;
  logic [15:0]   hit_count, miss_count;

  always #5 clock = ~clock;

  cache_frontend #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .cache_addr(cache_addr), .cache_val(cache_val),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_hit(cache_hit), .cache_out_val(cache_out_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed {
    logic          hit;
    logic          err;
    logic [LW-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Cache model: registered hit/data. A write to a non-resident line
  // installs it after 4 missing lookups (eviction). Hit is held when idle,
  // so it is stale during WR_ISSUE. 'stuck' forces hit low.
  logic [255:0]  res;
  logic [LW-1:0] mem [256];
  logic          m_hit;
  logic [LW-1:0] m_out;
  int            fill_m;
  bit            stuck = 1'b0;

  assign cache_hit     = m_hit;
  assign cache_out_val = m_out;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res          <= '0;
      res[8'h10]   <= 1'b1;
      mem[8'h10]   <= 32'hDEADBEEF;
      m_hit        <= 1'b0;
      m_out        <= '0;
      fill_m       <= 0;
    end else if (cache_read) begin
      m_hit  <= res[cache_addr] && !stuck;
      m_out  <= res[cache_addr] ? mem[cache_addr] : 32'hBAD0BAD0;
      fill_m <= 0;
    end else if (cache_write) begin
      if (stuck) begin
        m_hit <= 1'b0;
      end else if (res[cache_addr]) begin
        mem[cache_addr] <= cache_val;
        m_hit           <= 1'b1;
      end else if (fill_m == 4) begin
        res[cache_addr] <= 1'b1;
        mem[cache_addr] <= cache_val;
        m_hit           <= 1'b1;
      end else begin
        fill_m <= fill_m + 1;
        m_hit  <= 1'b0;
      end
    end else begin
      fill_m <= 0;
    end
  end

  // Stimulus: called at a negedge while IDLE; returns at the first negedge
  // after the accepting edge.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; cyc=1 is the first cycle after acceptance.
  task automatic wait_rsp(output bit ok, output int cyc, output int rd, output int wr,
                          output int both);
    ok = 1'b0; cyc = 0; rd = 0; wr = 0; both = 0;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid) begin
        ok = 1'b1; cyc = c;
        break;
      end
      rd   += int'(cache_read);
      wr   += int'(cache_write);
      both += int'(cache_read && cache_write);
      @(negedge clock);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({req_ready, cache_read, cache_write, rsp_valid, rsp_hit, rsp_err} !== 6'b0 ||
        rsp_data !== '0 || cache_addr !== '0 || cache_val !== '0 ||
        hit_count !== 16'd0 || miss_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b rd=%b wr=%b vld=%b hc=%0d mc=%0d addr=%h expected all zero",
               req_ready, cache_read, cache_write, rsp_valid, hit_count, miss_count, cache_addr);
    end
    #2 reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL reset_release_pre got req_ready=%b expected 0", req_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_first_edge got req_ready=%b expected 1", req_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_read_hit();
    bit ok; int cyc, rd, wr, both; rsp_t e;
    sb.push_back('{hit: 1'b1, err: 1'b0, data: 32'hDEADBEEF});
    issue(1'b0, 8'h10, '0);
    wait_rsp(ok, cyc, rd, wr, both);
    checks++;
    if (!ok || cyc != 3 || rd != 1 || wr != 0 || both != 0) begin
      failures++;
      $display("FAIL read_hit_timing got ok=%0b cyc=%0d rd=%0d wr=%0d expected ok=1 cyc=3 rd=1 wr=0",
               ok, cyc, rd, wr);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_hit !== e.hit || rsp_err !== e.err || rsp_data !== e.data || cache_addr !== 8'h10) begin
      failures++;
      $display("FAIL read_hit_rsp got hit=%b err=%b data=%h addr=%h expected hit=%b err=%b data=%h addr=10",
               rsp_hit, rsp_err, rsp_data, cache_addr, e.hit, e.err, e.data);
    end
    consume();
    checks++;
    if (hit_count !== 16'd1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_hit_after got hc=%0d rdy=%b vld=%b expected hc=1 rdy=1 vld=0",
               hit_count, req_ready, rsp_valid);
    end
  endtask

  // Follows a read hit, so the model's hit is stale-high during WR_ISSUE.
  task automatic test_write_miss();
    bit ok; int cyc, rd, wr, both; rsp_t e;
    sb.push_back('{hit: 1'b0, err: 1'b0, data: '0});
    issue(1'b1, 8'h20, 32'h1);
    wait_rsp(ok, cyc, rd, wr, both);
    checks++;
    if (!ok || cyc != 7 || wr != 6 || rd != 0 || both != 0 || cache_write !== 1'b0) begin
      failures++;
      $display("FAIL write_miss_timing got ok=%0b cyc=%0d wr=%0d rd=%0d cw=%b expected ok=1 cyc=7 wr=6 rd=0 cw=0",
               ok, cyc, wr, rd, cache_write);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_hit !== e.hit || rsp_err !== e.err || rsp_data !== e.data || cache_val !== 32'h1) begin
      failures++;
      $display("FAIL write_miss_rsp got hit=%b err=%b data=%h val=%h expected hit=%b err=%b data=%h val=1",
               rsp_hit, rsp_err, rsp_data, cache_val, e.hit, e.err, e.data);
    end
    consume();
    checks++;
    if (miss_count !== 16'd1 || hit_count !== 16'd1) begin
      failures++;
      $display("FAIL write_miss_count got hc=%0d mc=%0d expected hc=1 mc=1", hit_count, miss_count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc, rd, wr, both; rsp_t e;
    sb.push_back('{hit: 1'b1, err: 1'b0, data: 32'h1});
    sb.push_back('{hit: 1'b0, err: 1'b0, data: '0});
    issue(1'b0, 8'h20, '0);
    wait_rsp(ok, cyc, rd, wr, both);
    e = sb.pop_front();
    checks++;
    if (!ok || rsp_hit !== e.hit || rsp_err !== e.err || rsp_data !== e.data) begin
      failures++;
      $display("FAIL readback_rsp got ok=%0b hit=%b err=%b data=%h expected hit=%b err=%b data=%h",
               ok, rsp_hit, rsp_err, rsp_data, e.hit, e.err, e.data);
    end
    consume();
    issue(1'b0, 8'h55, '0);
    wait_rsp(ok, cyc, rd, wr, both);
    e = sb.pop_front();
    checks++;
    if (!ok || rd != 1 || rsp_hit !== e.hit || rsp_err !== e.err || rsp_data !== e.data) begin
      failures++;
      $display("FAIL read_miss_rsp got ok=%0b rd=%0d hit=%b err=%b data=%h expected rd=1 hit=%b err=%b data=%h",
               ok, rd, rsp_hit, rsp_err, rsp_data, e.hit, e.err, e.data);
    end
    consume();
    checks++;
    if (hit_count !== 16'd2 || miss_count !== 16'd2) begin
      failures++;
      $display("FAIL read_miss_count got hc=%0d mc=%0d expected hc=2 mc=2", hit_count, miss_count);
    end
  endtask

  task automatic test_timeout();
    bit ok; int cyc, rd, wr, both; rsp_t e;
    stuck = 1'b1;
    sb.push_back('{hit: 1'b0, err: 1'b1, data: '0});
    issue(1'b1, 8'h40, 32'h77);
    wait_rsp(ok, cyc, rd, wr, both);
    checks++;
    if (!ok || cyc != 10 || wr != 9 || cache_write !== 1'b0) begin
      failures++;
      $display("FAIL timeout_timing got ok=%0b cyc=%0d wr=%0d cw=%b expected ok=1 cyc=10 wr=9 cw=0",
               ok, cyc, wr, cache_write);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_hit !== e.hit || rsp_err !== e.err || rsp_data !== e.data) begin
      failures++;
      $display("FAIL timeout_rsp got hit=%b err=%b data=%h expected hit=%b err=%b data=%h",
               rsp_hit, rsp_err, rsp_data, e.hit, e.err, e.data);
    end
    consume();
    stuck = 1'b0;
    checks++;
    if (miss_count !== 16'd3) begin
      failures++; $display("FAIL timeout_count got mc=%0d expected 3", miss_count);
    end
  endtask

  task automatic test_backpressure_sat();
    bit ok; int cyc, rd, wr, both; rsp_t e;
    // Preload the hit counter at its ceiling instead of running 65535 hits.
    force dut.hit_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.hit_count_q;
    sb.push_back('{hit: 1'b1, err: 1'b0, data: 32'hDEADBEEF});
    issue(1'b0, 8'h10, '0);
    // A competing request held during the operation must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h99; req_data = 32'h5;
    wait_rsp(ok, cyc, rd, wr, both);
    e = sb.pop_front();
    checks++;
    if (!ok || wr != 0 || rsp_hit !== e.hit || rsp_data !== e.data || rsp_err !== e.err) begin
      failures++;
      $display("FAIL bp_rsp got ok=%0b wr=%0d hit=%b err=%b data=%h expected hit=%b err=%b data=%h",
               ok, wr, rsp_hit, rsp_err, rsp_data, e.hit, e.err, e.data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== e.hit || rsp_err !== e.err || rsp_data !== e.data ||
          req_ready !== 1'b0 || cache_write !== 1'b0 || cache_addr !== 8'h10) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got vld=%b hit=%b data=%h rdy=%b cw=%b addr=%h expected vld=1 hit=1 data=%h rdy=0 cw=0 addr=10",
                 i, rsp_valid, rsp_hit, rsp_data, req_ready, cache_write, cache_addr, e.data);
      end
    end
    req_valid = 1'b0;
    consume();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || hit_count !== 16'hFFFF || sb.size() != 0) begin
      failures++;
      $display("FAIL bp_release_sat got rdy=%b vld=%b hc=%h sb=%0d expected rdy=1 vld=0 hc=ffff sb=0",
               req_ready, rsp_valid, hit_count, sb.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    stuck = 1'b1;
    issue(1'b1, 8'h40, 32'h9);
    repeat (3) @(negedge clock);
    checks++;
    if (cache_write !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got cw=%b expected 1", cache_write);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cache_write !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async got cw=%b vld=%b rdy=%b expected 0 0 0", cache_write, rsp_valid, req_ready);
    end
    @(negedge clock);
    #2 reset_n = 1'b1;
    stuck = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_release got rdy=%b expected 1", req_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      seen += int'(rsp_valid === 1'b1);
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_mid_no_rsp got rsp_valid cycles=%0d expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_miss();
    test_back_to_back();
    test_timeout();
    test_backpressure_sat();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_frontend.md
CACHE_FRONTEND -- requirements
Module: cache_frontend

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: request address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 32: data width.
REQ-003 SHALL have parameter K, default 2: cache associativity, used to size the write timeout.
REQ-004 SHALL have parameter TIMEOUT, default 2*K+4: maximum cycles spent in WR_WAIT.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  frontend accepts a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_data  in  LINE_WIDTH  write data.
- cache_addr  out  ADDR_WIDTH  address to cache.
- cache_val  out  LINE_WIDTH  write data to cache.
- cache_read  out  1  cache read strobe.
- cache_write  out  1  cache write strobe.
- cache_hit  in  1  cache hit, registered by the cache.
- cache_out_val  in  LINE_WIDTH  cache read data, registered.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_hit  out  1  address was resident on first lookup.
- rsp_err  out  1  write timed out.
- rsp_data  out  LINE_WIDTH  read data; 0 on miss and on writes.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Function
REQ-006 SHALL implement states IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, WR_WAIT and RESP; all outputs SHALL be registered.
REQ-007 SHALL drive req_ready=1 only in IDLE; a request SHALL be accepted on an edge with req_valid&&req_ready, and req_addr/req_data SHALL be latched into cache_addr/cache_val at that edge.
REQ-008 SHALL hold cache_addr and cache_val constant from acceptance until the return to IDLE.
REQ-009 SHALL never assert cache_read and cache_write in the same cycle.
REQ-010 SHALL, on read acceptance, go to RD_ISSUE with cache_read=1 for exactly one cycle, then go to RD_CAPT with cache_read=0.
REQ-011 SHALL, in RD_CAPT, sample cache_hit and cache_out_val, set rsp_hit=cache_hit, set rsp_data=cache_out_val if hit else 0, set rsp_err=0, and go to RESP.
REQ-012 SHALL, on write acceptance, go to WR_ISSUE with cache_write=1 for one cycle, then go to WR_WAIT with cache_write still 1.
REQ-013 SHALL, on the first WR_WAIT cycle, record cache_hit as rsp_hit; cache_hit SHALL be ignored during WR_ISSUE because it is stale.
REQ-014 SHALL leave WR_WAIT for RESP, with cache_write cleared on that same edge, on the first WR_WAIT cycle where cache_hit=1; rsp_err=0 and rsp_data=0 in this case.
REQ-015 SHALL count WR_WAIT cycles with a counter that clears on WR_ISSUE entry.
- When the count reaches TIMEOUT with cache_hit still 0: go to RESP with rsp_err=1 and cache_write cleared.
REQ-016 SHALL tolerate the one overlapping cache cycle after the strobe is dropped; a rewrite of the same address and value is idempotent.
REQ-017 SHALL hold rsp_valid=1 and all rsp_* stable in RESP until rsp_ready=1, then return to IDLE on that edge; req_ready SHALL rise on the following cycle, with no same-cycle bypass.
REQ-018 SHALL increment hit_count when rsp_hit is recorded as 1, and miss_count when it is recorded as 0; each SHALL saturate at 16'hFFFF and never wrap.
REQ-019 SHALL ignore req_valid outside IDLE; requests are not queued.

Reset
REQ-020 SHALL, when reset_n=0, asynchronously force state=IDLE, req_ready=0, cache_read=0, cache_write=0, rsp_valid=0, rsp_hit=0, rsp_err=0, rsp_data=0, cache_addr=0, cache_val=0, hit_count=0, miss_count=0 and the wait counter=0.
REQ-021 SHALL drive req_ready=1 on the first clock edge after reset_n deasserts.
REQ-022 SHALL abandon any in-flight operation on reset assertion mid-operation, with no response issued afterwards.

Verification
REQ-023 Read hit: cache model resident at 8'h10 with 32'hDEADBEEF; read 8'h10 -> rsp_valid 3 cycles after acceptance, rsp_hit=1, rsp_data=32'hDEADBEEF, hit_count=1.
REQ-024 Read miss: read 8'h55 with the address absent -> rsp_hit=0, rsp_data=0, miss_count=1, cache_read high for exactly 1 cycle.
REQ-025 Write miss with eviction: K=2, both ways referenced, write 8'h20/32'h1 -> cache_write held until cache_hit=1 (4 cycles after the first lookup), rsp_hit=0, rsp_err=0; a following read of 8'h20 returns 32'h1.
REQ-026 Timeout: cache_hit stuck at 0 on a write -> after TIMEOUT=8 WR_WAIT cycles, rsp_err=1 and cache_write=0.
REQ-027 Backpressure and saturation: rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; hit_count preloaded via 65535 hits and one more hit -> stays 16'hFFFF.
REQ-028 Reset mid-write: reset_n pulled low in WR_WAIT -> cache_write=0 immediately and no response; req_ready=1 on the first edge after release.
